// File: rtl/scs8hd_dlxbn_rf_if.sv
// Request/response bundle for the latch register file.
// Signal names follow the original cell's pin names.
interface scs8hd_dlxbn_rf_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
);
   logic             WE;
   logic [AW-1:0]    WADDR;
   logic [WIDTH-1:0] D;
   logic             RE;
   logic [AW-1:0]    RADDR;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] QN;
   logic             RVALID;
   logic [DEPTH-1:0] VLD;

   modport master (output WE, WADDR, D, RE, RADDR, input Q, QN, RVALID, VLD);
   modport slave  (input WE, WADDR, D, RE, RADDR, output Q, QN, RVALID, VLD);
endinterface

// File: rtl/scs8hd_dlxbn_rf.sv
// WIDTH x DEPTH register file built from transparent-low latches, with a
// flopped write staging stage and a registered read port.
module scs8hd_dlxbn_rf_cell #(
   parameter int WIDTH = 8
) (
   input  logic             gaten,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_latch begin
      if (!gaten) q <= d;
   end
endmodule

module scs8hd_dlxbn_rf #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AW        = 2,
   parameter bit RD_BYPASS = 1'b1
) (
   input logic                 CLK,
   input logic                 RESETB,
   scs8hd_dlxbn_rf_if.slave    bus
);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [DEPTH-1:0]            wsel_d, wsel_q, vld_q, gaten;
   logic [WIDTH-1:0]            wdata_q, q_q, q_d, rd_data;
   logic                        rvalid_q, w_ok, r_ok;
   logic [DEPTH-1:0][WIDTH-1:0] mem;

   assign w_ok = bus.WE && ({1'b0, bus.WADDR} < DEPTH_W);
   assign r_ok = {1'b0, bus.RADDR} < DEPTH_W;

   always_comb begin
      wsel_d  = '0;
      rd_data = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (w_ok && bus.WADDR == AW'(e)) wsel_d[e] = 1'b1;
         if (bus.RADDR == AW'(e) && vld_q[e]) rd_data = mem[e];
      end
   end

   // Write-first only applies when the same-edge write is actually accepted.
   always_comb begin
      q_d = q_q;
      if (bus.RE) begin
         if (!r_ok)
            q_d = '0;
         else if (RD_BYPASS && w_ok && bus.WADDR == bus.RADDR)
            q_d = bus.D;
         else
            q_d = rd_data;
      end
   end

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         wsel_q   <= '0;
         wdata_q  <= '0;
         vld_q    <= '0;
         q_q      <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wsel_q   <= wsel_d;
         if (w_ok) wdata_q <= bus.D;
         vld_q    <= vld_q | wsel_d;
         q_q      <= q_d;
         rvalid_q <= bus.RE;
      end
   end

   // Gate opens only in the low phase after a staged write; select is a flop
   // output so the gate cannot glitch, and reset slams every gate shut.
   assign gaten = {DEPTH{CLK}} | ~wsel_q | {DEPTH{~RESETB}};

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      scs8hd_dlxbn_rf_cell #(.WIDTH(WIDTH)) u_cell (
         .gaten (gaten[e]),
         .d     (wdata_q),
         .q     (mem[e])
      );
   end

   assign bus.Q      = q_q;
   assign bus.QN     = ~q_q;
   assign bus.RVALID = rvalid_q;
   assign bus.VLD    = vld_q;
endmodule

// File: tb/tb_scs8hd_dlxbn_rf.sv
// Bench: two configurations (write-first 4x8 and read-first 5x8) driven by
// directed then random traffic, checked against an array-based model.
module tb_scs8hd_dlxbn_rf;
   logic CLK, RESETB;
   int   n_chk, n_err;

   logic       t_we[2], t_re[2];
   logic [2:0] t_wa[2], t_ra[2];
   logic [7:0] t_d[2];

   scs8hd_dlxbn_rf_if #(.WIDTH(8), .DEPTH(4), .AW(2)) ifa ();
   scs8hd_dlxbn_rf_if #(.WIDTH(8), .DEPTH(5), .AW(3)) ifb ();

   assign ifa.WE = t_we[0];  assign ifa.WADDR = t_wa[0][1:0];  assign ifa.D = t_d[0];
   assign ifa.RE = t_re[0];  assign ifa.RADDR = t_ra[0][1:0];
   assign ifb.WE = t_we[1];  assign ifb.WADDR = t_wa[1];       assign ifb.D = t_d[1];
   assign ifb.RE = t_re[1];  assign ifb.RADDR = t_ra[1];

   scs8hd_dlxbn_rf #(.WIDTH(8), .DEPTH(4), .AW(2), .RD_BYPASS(1'b1)) dut_a (
      .CLK(CLK), .RESETB(RESETB), .bus(ifa));
   scs8hd_dlxbn_rf #(.WIDTH(8), .DEPTH(5), .AW(3), .RD_BYPASS(1'b0)) dut_b (
      .CLK(CLK), .RESETB(RESETB), .bus(ifb));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: entry array, written flags, last response.
   logic [7:0] m_mem[2][8];
   logic [7:0] m_vld[2];
   logic [7:0] m_q[2];
   logic       m_rv[2];
   int         m_gate[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int dep(input int k);
      return (k == 0) ? 4 : 5;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_q[k] = 8'h00; m_vld[k] = 8'h00; m_rv[k] = 1'b0; m_gate[k] = -1;
      end
   endtask

   task automatic model_edge(input int k);
      int wa, ra;
      logic [7:0] nq;
      wa = int'(t_wa[k]);
      ra = int'(t_ra[k]);
      nq = m_q[k];
      if (t_re[k]) begin
         if (ra >= dep(k))                        nq = 8'h00;
         else if (k == 0 && t_we[k] && wa == ra)  nq = t_d[k];
         else                                     nq = m_vld[k][ra] ? m_mem[k][ra] : 8'h00;
      end
      m_rv[k]   = t_re[k];
      m_gate[k] = -1;
      if (t_we[k] && wa < dep(k)) begin
         m_mem[k][wa] = t_d[k];
         m_vld[k][wa] = 1'b1;
         m_gate[k]    = wa;
      end
      m_q[k] = nq;
   endtask

   task automatic check_outs();
      logic [7:0] qn0, qn1;
      qn0 = ~m_q[0];
      qn1 = ~m_q[1];
      chk("a.q",   ifa.Q,      m_q[0]);
      chk("a.qn",  ifa.QN,     qn0);
      chk("a.rv",  ifa.RVALID, m_rv[0]);
      chk("a.vld", ifa.VLD,    m_vld[0] & 8'h0F);
      chk("b.q",   ifb.Q,      m_q[1]);
      chk("b.qn",  ifb.QN,     qn1);
      chk("b.rv",  ifb.RVALID, m_rv[1]);
      chk("b.vld", ifb.VLD,    m_vld[1] & 8'h1F);
   endtask

   task automatic check_gates();
      logic [7:0] ga, gb;
      ga = 8'hFF; gb = 8'hFF;
      if (m_gate[0] >= 0) ga[m_gate[0]] = 1'b0;
      if (m_gate[1] >= 0) gb[m_gate[1]] = 1'b0;
      chk("a.gaten", dut_a.gaten, ga & 8'h0F);
      chk("b.gaten", dut_b.gaten, gb & 8'h1F);
   endtask

   // Inputs are changed only in the low phase; returns at negedge+1.
   task automatic tick();
      @(posedge CLK);
      model_edge(0);
      model_edge(1);
      #1 check_outs();
      @(negedge CLK);
      #1 check_gates();
   endtask

   task automatic set_in(input int k, input logic we, input logic [2:0] wa, input logic [7:0] d,
                         input logic re, input logic [2:0] ra);
      t_we[k] = we; t_wa[k] = wa; t_d[k] = d; t_re[k] = re; t_ra[k] = ra;
   endtask

   task automatic idle();
      set_in(0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      set_in(1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      idle();
      model_reset();
      RESETB = 1'b0;
      #2 check_outs();
      chk("rst.qn", ifa.QN, 8'hFF);
      @(negedge CLK);
      #1 RESETB = 1'b1;

      // Read of an unwritten entry returns zero with RVALID.
      set_in(0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
      tick();
      chk("t1.q",  ifa.Q, 8'h00);
      chk("t1.rv", ifa.RVALID, 1'b1);

      set_in(0, 1'b1, 3'd1, 8'hA5, 1'b0, 3'd0);
      tick();
      set_in(0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
      tick();
      chk("t2.q",   ifa.Q,   8'hA5);
      chk("t2.qn",  ifa.QN,  8'h5A);
      chk("t2.vld", ifa.VLD, 4'b0010);

      // Same-edge read/write collision: write-first vs read-first.
      set_in(0, 1'b1, 3'd3, 8'h11, 1'b0, 3'd0);
      set_in(1, 1'b1, 3'd3, 8'h11, 1'b0, 3'd0);
      tick();
      set_in(0, 1'b1, 3'd3, 8'h3C, 1'b1, 3'd3);
      set_in(1, 1'b1, 3'd3, 8'h3C, 1'b1, 3'd3);
      tick();
      chk("t3.a_byp", ifa.Q, 8'h3C);
      chk("t3.b_old", ifb.Q, 8'h11);
      set_in(0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
      set_in(1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
      tick();
      chk("t3.a_new", ifa.Q, 8'h3C);
      chk("t3.b_new", ifb.Q, 8'h3C);
      idle();

      // Back-to-back fill then back-to-back readback.
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1'b1, 3'(i), 8'(i + 1), 1'b0, 3'd0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i));
         tick();
         chk("t4.q", ifa.Q, 8'(i + 1));
      end
      idle();

      // Out-of-range address on the 5-entry instance.
      set_in(1, 1'b1, 3'd6, 8'hFF, 1'b0, 3'd0);
      tick();
      set_in(1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6);
      tick();
      chk("t5.q",   ifb.Q,   8'h00);
      chk("t5.rv",  ifb.RVALID, 1'b1);
      chk("t5.vld", ifb.VLD, 5'b01000);
      idle();

      // Reset during the latch phase of a write.
      set_in(0, 1'b1, 3'd0, 8'h77, 1'b0, 3'd0);
      set_in(1, 1'b1, 3'd0, 8'h77, 1'b0, 3'd0);
      tick();
      idle();
      #1 RESETB = 1'b0;
      model_reset();
      #1 check_outs();
      check_gates();
      chk("t6.vld", ifa.VLD, 4'b0000);
      #1 RESETB = 1'b1;
      set_in(0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
      set_in(1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
      tick();
      chk("t6.q", ifa.Q, 8'h00);

      // Random traffic with biased address collisions.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 2; k++) begin
            logic [2:0] wa, ra;
            wa = (k == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            ra = (k == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ra = wa;
            set_in(k, 1'($urandom_range(0, 1)), wa, 8'($urandom),
                   1'($urandom_range(0, 1)), ra);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
